control_termostato: RTL and testbench

Closed-loop thermostat stage between the ADC0809 sampler and the motor PWM driver of the refrigeration system. It averages raw 8-bit temperature codes over four samples and holds a keypad-loaded setpoint. It runs a hysteresis state machine with minimum on/off compressor timers and drives the 2-bit `giro` command consumed by `motor`. It also raises a delayed over-temperature alarm flag.

---
 rtl/control_termostato.sv | 174 +++++++++++++++++
 tb/tb_control_termostato.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_termostato.sv
// Thermostat stage: 4-sample averaging filter, setpoint register, hysteresis FSM
// with minimum on/off compressor timers, and a delayed over-temperature alarm.
module control_termostato #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned MIN_ON      = 30,
  parameter int unsigned MIN_OFF     = 60,
  parameter int unsigned HYST        = 2,
  parameter int unsigned BOOST       = 8,
  parameter int unsigned ALARM_DELTA = 16,
  parameter int unsigned ALARM_TICKS = 10,
  parameter logic [7:0]  SP_DEFAULT  = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] temp,
  input  logic       temp_valid,
  input  logic [7:0] setpoint,
  input  logic       sp_load,
  output logic [1:0] giro,
  output logic       alarm,
  output logic [7:0] temp_avg,
  output logic       avg_valid,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_WAIT = 2'b00,
    S_OFF  = 2'b01,
    S_COOL = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  function automatic logic [15:0] dec_sat(input logic [15:0] v);
    return (v == 16'd0) ? v : v - 16'd1;
  endfunction

  function automatic logic [8:0] sub_sat(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? a - b : 9'd0;
  endfunction

  logic [7:0]    r_shift [4];
  logic [9:0]    r_sum;
  logic [2:0]    r_fill;
  logic          r_avg_valid;
  logic [7:0]    r_sp;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_on_tmr;
  logic [15:0]   r_off_tmr;
  logic [15:0]   r_alm_cnt;
  state_t        r_state;
  logic [1:0]    r_giro;

  logic          w_tick;
  logic [8:0]    w_avg9;
  logic [8:0]    w_sp9;
  logic [8:0]    w_hi;
  logic [8:0]    w_lo;
  logic [8:0]    w_boost;
  logic [8:0]    w_alm;
  logic          w_above_hi;
  logic          w_below_lo;
  logic          w_fast;
  logic          w_over;

  // Filter: running sum always equals the sum of the four stored samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_shift[i] <= 8'd0;
      r_sum       <= 10'd0;
      r_fill      <= 3'd0;
      r_avg_valid <= 1'b0;
    end else if (temp_valid) begin
      r_shift[0] <= temp;
      for (int i = 1; i < 4; i++) r_shift[i] <= r_shift[i-1];
      r_sum <= r_sum + {2'b00, temp} - {2'b00, r_shift[3]};
      if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
      if (r_fill == 3'd3) r_avg_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp <= SP_DEFAULT;
    end else if (sp_load) begin
      r_sp <= setpoint;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick  = (r_presc == PW'(TICK_DIV - 1));
  assign temp_avg = r_sum[9:2];

  // Thresholds in 9 bits so values above 255 stay unreachable instead of wrapping
  assign w_avg9  = {1'b0, r_sum[9:2]};
  assign w_sp9   = {1'b0, r_sp};
  assign w_hi    = w_sp9 + 9'(HYST);
  assign w_lo    = sub_sat(w_sp9, 9'(HYST));
  assign w_boost = w_sp9 + 9'(BOOST);
  assign w_alm   = w_sp9 + 9'(ALARM_DELTA);

  assign w_above_hi = (w_avg9 > w_hi);
  assign w_below_lo = (w_avg9 < w_lo);
  assign w_fast     = (w_avg9 >= w_boost);
  assign w_over     = (w_avg9 >= w_alm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_WAIT;
      r_giro    <= 2'b00;
      r_off_tmr <= 16'(MIN_OFF);
      r_on_tmr  <= 16'd0;
    end else begin
      if (w_tick) begin
        r_on_tmr  <= dec_sat(r_on_tmr);
        r_off_tmr <= dec_sat(r_off_tmr);
      end
      case (r_state)
        S_WAIT: begin
          r_giro <= 2'b00;
          if (r_avg_valid) r_state <= S_OFF;
        end
        S_OFF: begin
          r_giro <= 2'b00;
          if (r_off_tmr == 16'd0 && w_above_hi) begin
            r_state  <= S_COOL;
            r_on_tmr <= 16'(MIN_ON);
            r_giro   <= w_fast ? 2'b10 : 2'b01;
          end
        end
        S_COOL: begin
          if (r_on_tmr == 16'd0 && w_below_lo) begin
            r_state   <= S_OFF;
            r_off_tmr <= 16'(MIN_OFF);
            r_giro    <= 2'b00;
          end else begin
            r_giro <= w_fast ? 2'b10 : 2'b01;
          end
        end
        default: begin
          r_state <= S_OFF;
          r_giro  <= 2'b00;
        end
      endcase
    end
  end

  // Alarm counter restarts whenever the average falls back below the alarm level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alm_cnt <= 16'd0;
    end else if (!(r_avg_valid && w_over)) begin
      r_alm_cnt <= 16'd0;
    end else if (w_tick && r_alm_cnt != 16'(ALARM_TICKS)) begin
      r_alm_cnt <= r_alm_cnt + 16'd1;
    end
  end

  assign alarm     = (r_alm_cnt == 16'(ALARM_TICKS));
  assign avg_valid = r_avg_valid;
  assign giro      = r_giro;
  assign state     = r_state;

endmodule

// File: tb/tb_control_termostato.sv
// Directed bench for control_termostato with short timers (tick = 10 cycles).
module tb_control_termostato;

  logic       clk;
  logic       reset;
  logic [7:0] temp;
  logic       temp_valid;
  logic [7:0] setpoint;
  logic       sp_load;
  logic [1:0] giro;
  logic       alarm;
  logic [7:0] temp_avg;
  logic       avg_valid;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  control_termostato #(
    .TICK_DIV(10), .MIN_ON(3), .MIN_OFF(3), .HYST(2), .BOOST(8),
    .ALARM_DELTA(16), .ALARM_TICKS(2), .SP_DEFAULT(8'd100)
  ) dut (
    .clk(clk), .reset(reset), .temp(temp), .temp_valid(temp_valid),
    .setpoint(setpoint), .sp_load(sp_load), .giro(giro), .alarm(alarm),
    .temp_avg(temp_avg), .avg_valid(avg_valid), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    temp = v;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic strobe_sp(input logic [7:0] v, input logic [7:0] sp);
    @(negedge clk);
    temp = v;
    temp_valid = 1'b1;
    setpoint = sp;
    sp_load = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    sp_load = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget, output int used);
    used = 0;
    while (state !== exp && used < budget) begin
      @(negedge clk);
      used++;
    end
  endtask

  int n;
  int cyc;

  initial begin
    reset = 1'b1;
    temp = 8'd0;
    temp_valid = 1'b0;
    setpoint = 8'd0;
    sp_load = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_giro", giro, 0);
    check("rst_alarm", alarm, 0);
    check("rst_avg", temp_avg, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_state", state, 0);
    reset = 1'b0;

    repeat (3) strobe(8'd110);
    check("fill3_valid", avg_valid, 0);
    check("fill3_giro", giro, 0);
    check("fill3_state", state, 0);
    strobe(8'd110);
    check("fill4_valid", avg_valid, 1);
    check("fill4_avg", temp_avg, 110);
    check("fill4_state_wait", state, 0);
    @(negedge clk);
    check("fill4_state_off", state, 1);

    wait_state(2'b10, 40, n);
    check("first_cool", state, 2);
    check("first_cool_boost", giro, 2'b10);

    repeat (4) strobe(8'd104);
    check("avg104", temp_avg, 104);
    @(negedge clk);
    check("normal_speed", giro, 2'b01);
    check("normal_state", state, 2);

    repeat (40) @(negedge clk);
    repeat (4) strobe(8'd98);
    check("avg98", temp_avg, 98);
    @(negedge clk);
    check("at_lo_stays_cool", state, 2);
    check("at_lo_giro", giro, 2'b01);
    strobe(8'd97);
    check("avg97", temp_avg, 97);
    @(negedge clk);
    check("below_lo_off", state, 1);
    check("below_lo_giro", giro, 0);

    cyc = 0;
    repeat (4) strobe(8'd103);
    cyc += 8;
    check("avg103", temp_avg, 103);
    check("min_off_hold", state, 1);
    wait_state(2'b10, 40, n);
    cyc += n;
    check("recool", state, 2);
    check("recool_giro", giro, 2'b01);
    check("min_off_elapsed", 16'(cyc >= 21), 1);

    strobe(8'd100); strobe(8'd104); strobe(8'd100); strobe(8'd104);
    check("avg102", temp_avg, 102);
    strobe(8'd0);
    check("drop1", temp_avg, 77);
    strobe(8'd0);
    check("drop2", temp_avg, 51);
    strobe(8'd0);
    check("drop3", temp_avg, 26);
    strobe(8'd0);
    check("drop4", temp_avg, 0);

    strobe_sp(8'd255, 8'd250);
    repeat (3) strobe(8'd255);
    check("avg255", temp_avg, 255);
    wait_state(2'b10, 45, n);
    check("sp250_cool", state, 2);
    @(negedge clk);
    check("sp250_normal", giro, 2'b01);
    repeat (30) @(negedge clk);
    check("sp250_no_alarm", alarm, 0);
    check("sp250_still_normal", giro, 2'b01);

    strobe_sp(8'd0, 8'd0);
    repeat (3) strobe(8'd0);
    check("sp0_avg", temp_avg, 0);
    repeat (40) @(negedge clk);
    check("sp0_never_exit", state, 2);
    check("sp0_giro", giro, 2'b01);
    check("sp0_no_alarm", alarm, 0);

    strobe_sp(8'd120, 8'd100);
    repeat (3) strobe(8'd120);
    check("avg120", temp_avg, 120);
    check("alarm_not_yet", alarm, 0);
    n = 0;
    while (alarm !== 1'b1 && n < 25) begin
      @(negedge clk);
      n++;
    end
    check("alarm_set", alarm, 1);
    wait_state(2'b10, 45, n);
    check("alarm_cool", state, 2);
    @(negedge clk);
    check("alarm_giro_boost", giro, 2'b10);
    check("alarm_held", alarm, 1);

    strobe(8'd80);
    check("avg110", temp_avg, 110);
    check("alarm_before_clear", alarm, 1);
    @(negedge clk);
    check("alarm_cleared", alarm, 0);
    check("cool_110_giro", giro, 2'b10);

    #2 reset = 1'b1;
    #1;
    check("async_giro", giro, 0);
    check("async_state", state, 0);
    check("async_avg", temp_avg, 0);
    check("async_valid", avg_valid, 0);
    check("async_alarm", alarm, 0);
    @(negedge clk);
    reset = 1'b0;

    cyc = 0;
    repeat (3) strobe(8'd110);
    check("refill3_valid", avg_valid, 0);
    strobe(8'd110);
    cyc += 8;
    check("refill4_valid", avg_valid, 1);
    check("refill4_avg", temp_avg, 110);
    wait_state(2'b10, 40, n);
    cyc += n;
    check("post_reset_cool", state, 2);
    check("post_reset_min_off", 16'(cyc >= 25), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
